serial_subtractor: RTL and testbench

Bit-serial WIDTH-bit subtractor computing diff = a − b − bin with borrow-out. It is the inverse-direction companion to the combinational ripple-carry adder datapath. It trades area for latency: one 1-bit full-subtractor cell is reused over WIDTH clock cycles under a start/busy/done handshake. It sits beside the adder so the ALU can offer ADD and SUB with matching operand and flag conventions.

---
 rtl/serial_subtractor_pkg.sv | 20 ++
 rtl/serial_subtractor_if.sv | 23 ++
 rtl/full_subtractor_1b.sv | 18 +
 rtl/serial_subtractor.sv | 83 ++++++++
 tb/tb_serial_subtractor.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_subtractor_pkg : FSM encodings and counter sizing helpers   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package serial_subtractor_pkg;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam int DEF_WIDTH = 4;
  localparam int CW        = $clog2(DEF_WIDTH);

  // Guards the counter against a zero-width result for degenerate widths.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_subtractor_if : start/busy/done request and result bundle   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);

endinterface
`default_nettype wire

// File: rtl/full_subtractor_1b.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | full_subtractor_1b : one-bit x - y - bi with borrow-out            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module full_subtractor_1b (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_subtractor : bit-serial a - b - bin, one bit per clock      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int               CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic             br;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             done_q;
  logic             d_bit;
  logic             bo_bit;

  full_subtractor_1b u_fs (
    .x  (sa[0]),
    .y  (sb[0]),
    .bi (br),
    .d  (d_bit),
    .bo (bo_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      sa     <= '0;
      sb     <= '0;
      sd     <= '0;
      br     <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == S_IDLE) begin
        if (bus.start) begin
          sa    <= bus.a;
          sb    <= bus.b;
          br    <= bus.bin;
          cnt   <= '0;
          state <= S_RUN;
        end
      end else begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        sd  <= {d_bit, sd[WIDTH-1:1]};
        br  <= bo_bit;
        cnt <= cnt + 1'b1;
        // Final bit: publish the completed difference in the same edge.
        if (cnt == LAST) begin
          diff_q <= {d_bit, sd[WIDTH-1:1]};
          bout_q <= bo_bit;
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
      end
    end
  end

  assign bus.busy = (state == S_RUN);
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_serial_subtractor : directed and swept checks, WIDTH = 4        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_serial_subtractor;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one start pulse, scrambles the inputs mid-run, then watches 3*W cycles.
  task automatic run_op(input logic [3:0] x, input logic [3:0] y, input logic bi,
                        output logic [4:0] res, output int lat, output int ndone,
                        output bit held);
    logic [4:0] prev;
    prev  = {bus.bout, bus.diff};
    held  = 1'b1;
    lat   = -1;
    ndone = 0;
    res   = 'x;
    bus.a = x; bus.b = y; bus.bin = bi; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.a     = 4'($urandom);
    bus.b     = 4'($urandom);
    bus.bin   = 1'($urandom);
    for (int i = 1; i <= 3 * W; i++) begin
      step();
      if (bus.done) begin
        ndone++;
        if (lat < 0) begin
          lat = i;
          res = {bus.bout, bus.diff};
        end
      end else if (lat < 0 && {bus.bout, bus.diff} !== prev) begin
        held = 1'b0;
      end else if (lat >= 0 && {bus.bout, bus.diff} !== res) begin
        held = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_vec++;
    if ({bus.busy, bus.done, bus.bout, bus.diff} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_state: got busy,done,bout,diff=%b expected %b",
               {bus.busy, bus.done, bus.bout, bus.diff}, 7'b0);
    end
  endtask

  task automatic test_directed();
    logic [3:0] ta [3] = '{4'd7, 4'd3, 4'd0};
    logic [3:0] tb [3] = '{4'd3, 4'd7, 4'd0};
    logic       tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [4:0] te [3] = '{5'b0_0100, 5'b1_1100, 5'b1_1111};
    logic [4:0] res;
    int lat, nd;
    bit held;
    for (int k = 0; k < 3; k++) begin
      run_op(ta[k], tb[k], tc[k], res, lat, nd, held);
      n_vec++;
      if (res !== te[k]) begin
        n_err++;
        $display("FAIL directed_%0d result: got %b expected %b", k, res, te[k]);
      end
      n_vec++;
      if (lat !== W || nd !== 1 || held !== 1'b1) begin
        n_err++;
        $display("FAIL directed_%0d protocol: got lat=%0d dones=%0d held=%0d expected lat=%0d dones=1 held=1",
                 k, lat, nd, held, W);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t1 = -1;
    int t2 = -1;
    int nd = 0;
    bit gap_ok = 1'b1;
    logic [4:0] r1 = 'x;
    logic [4:0] r2 = 'x;
    bus.a = 4'd9; bus.b = 4'd4; bus.bin = 1'b0; bus.start = 1'b1;
    step();
    for (int i = 1; i <= 9; i++) begin
      if (i == 2) begin
        bus.a = 4'd12;
        bus.b = 4'd2;
      end
      step();
      if (bus.done) begin
        nd++;
        if (t1 < 0) begin t1 = i; r1 = {bus.bout, bus.diff}; end
        else        begin t2 = i; r2 = {bus.bout, bus.diff}; end
      end
      if (!bus.busy && !bus.done) gap_ok = 1'b0;
    end
    bus.start = 1'b0;
    step();
    n_vec++;
    if (t1 !== 4 || r1 !== 5'b0_0101) begin
      n_err++;
      $display("FAIL b2b_first: got cycle=%0d result=%b expected cycle=4 result=%b", t1, r1, 5'b0_0101);
    end
    n_vec++;
    if (t2 !== 9 || r2 !== 5'b0_1010) begin
      n_err++;
      $display("FAIL b2b_second: got cycle=%0d result=%b expected cycle=9 result=%b", t2, r2, 5'b0_1010);
    end
    n_vec++;
    if (nd !== 2 || gap_ok !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_gap: got dones=%0d no_idle_gap=%0d expected dones=2 no_idle_gap=1", nd, gap_ok);
    end
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_after: got busy=%b done=%b expected busy=0 done=0", bus.busy, bus.done);
    end
  endtask

  task automatic test_reset_abort();
    int late = 0;
    bus.a = 4'd15; bus.b = 4'd1; bus.bin = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++;
    if ({bus.busy, bus.done, bus.bout, bus.diff} !== 7'b0) begin
      n_err++;
      $display("FAIL abort_state: got busy,done,bout,diff=%b expected %b",
               {bus.busy, bus.done, bus.bout, bus.diff}, 7'b0);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.done || bus.busy) late++;
    end
    n_vec++;
    if (late !== 0) begin
      n_err++;
      $display("FAIL abort_quiet: got %0d active cycles expected 0", late);
    end
  endtask

  task automatic test_random();
    logic [3:0] x, y;
    logic       bi;
    logic [4:0] res, exp;
    int lat, nd;
    bit held;
    for (int k = 0; k < 10; k++) begin
      x  = 4'($urandom);
      y  = 4'($urandom);
      bi = 1'($urandom);
      exp = {1'b0, x} - {1'b0, y} - {4'b0, bi};
      run_op(x, y, bi, res, lat, nd, held);
      n_vec++;
      if (res !== exp || lat !== W || nd !== 1 || held !== 1'b1) begin
        n_err++;
        $display("FAIL random a=%0d b=%0d bin=%0d: got %b lat=%0d dones=%0d held=%0d expected %b lat=%0d dones=1 held=1",
                 x, y, bi, res, lat, nd, held, exp, W);
      end
    end
  endtask

  task automatic test_sweep();
    logic [4:0] res, exp;
    int lat, nd;
    bit held;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int bi = 0; bi < 2; bi++) begin
          exp = 5'(x) - 5'(y) - 5'(bi);
          run_op(4'(x), 4'(y), 1'(bi), res, lat, nd, held);
          n_vec++;
          if (res !== exp || lat !== W || nd !== 1 || held !== 1'b1) begin
            n_err++;
            $display("FAIL sweep a=%0d b=%0d bin=%0d: got %b lat=%0d dones=%0d held=%0d expected %b lat=%0d dones=1 held=1",
                     x, y, bi, res, lat, nd, held, exp, W);
          end
        end
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_abort();
    test_random();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
